// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative multiply/divide unit with HI/LO registers
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             cancel,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic             stall
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;

   logic [1:0]         state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   // multiplicand for multiply, divisor for divide
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   // multiply: {partial product, remaining multiplier bits}; divide: {remainder, quotient}
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic               is_div_q, is_div_d;
   logic               neg_res_q, neg_res_d;
   logic               neg_rem_q, neg_rem_d;
   logic               dz_q, dz_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   logic               op_mul, op_div, op_start, op_mthi, op_mtlo, op_listed, op_signed;
   logic               rs_neg, rt_neg;
   logic [WIDTH-1:0]   rs_abs, rt_abs;

   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH+1:0]   div_diff;
   logic               div_ok;
   logic [2*WIDTH-1:0] div_next;

   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix, rem_fix;

   // instruction decode and operand magnitude/sign extraction
   always_comb begin
      op_mul    = valid & ((funct == F_MULT) | (funct == F_MULTU));
      op_div    = valid & ((funct == F_DIV) | (funct == F_DIVU));
      op_start  = op_mul | op_div;
      op_mthi   = valid & (funct == F_MTHI);
      op_mtlo   = valid & (funct == F_MTLO);
      op_listed = op_start | op_mthi | op_mtlo
                | (valid & ((funct == F_MFHI) | (funct == F_MFLO)));
      op_signed = (funct == F_MULT) | (funct == F_DIV);
      rs_neg    = op_signed & rs_val[WIDTH-1];
      rt_neg    = op_signed & rt_val[WIDTH-1];
      rs_abs    = rs_neg ? -rs_val : rs_val;
      rt_abs    = rt_neg ? -rt_val : rt_val;
   end

   // one shift-add or restoring-divide step, plus the final sign correction
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_next  = {mul_sum, acc_q[WIDTH-1:1]};

      // the top remainder bit shifted out acts as the carry, so a set carry always subtracts
      div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
      div_ok    = ~div_diff[WIDTH+1];
      div_next  = {(div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                   acc_q[WIDTH-2:0], div_ok};

      prod_fix  = neg_res_q ? -acc_q : acc_q;
      // a zero divisor leaves |rs| in the remainder; restoring its sign yields rs unchanged
      quot_fix  = dz_q ? '1 : (neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
      rem_fix   = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
   end

   // FSM next state and register updates
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      opnd_d    = opnd_q;
      acc_d     = acc_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      dz_d      = dz_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      case (state_q)
         S_CALC: begin
            if (cancel) begin
               state_d = S_IDLE;
            end else begin
               acc_d = is_div_q ? div_next : mul_next;
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CNT_LAST) begin
                  state_d = S_FIX;
               end
            end
         end
         S_FIX: begin
            if (cancel) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
               if (is_div_q) begin
                  hi_d = rem_fix;
                  lo_d = quot_fix;
               end else begin
                  hi_d = prod_fix[2*WIDTH-1:WIDTH];
                  lo_d = prod_fix[WIDTH-1:0];
               end
            end
         end
         default: begin
            // IDLE and DONE both accept new work; DONE falls back to IDLE otherwise
            state_d = S_IDLE;
            if (!cancel) begin
               if (op_start) begin
                  state_d   = S_CALC;
                  cnt_d     = '0;
                  is_div_d  = op_div;
                  neg_res_d = rs_neg ^ rt_neg;
                  neg_rem_d = rs_neg;
                  dz_d      = op_div & (rt_val == '0);
                  opnd_d    = op_div ? rt_abs : rs_abs;
                  acc_d     = {{WIDTH{1'b0}}, (op_div ? rs_abs : rt_abs)};
               end else if (op_mthi) begin
                  hi_d = rs_val;
               end else if (op_mtlo) begin
                  lo_d = rs_val;
               end
            end
         end
      endcase
   end

   // state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         opnd_q    <= '0;
         acc_q     <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         opnd_q    <= opnd_d;
         acc_q     <= acc_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         dz_q      <= dz_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   // outputs
   always_comb begin
      hi       = hi_q;
      lo       = lo_q;
      busy     = (state_q == S_CALC) | (state_q == S_FIX);
      done     = (state_q == S_DONE);
      div_zero = done & dz_q;
      stall    = busy & op_listed;
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard testbench for mult_div_unit
module tb_mult_div_unit;

   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;
   localparam logic [5:0] F_ADD   = 6'h20;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [5:0]  funct;
   logic [31:0] rs_val, rt_val;
   logic        cancel;
   logic [31:0] hi, lo;
   logic        busy, done, div_zero, stall;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   passed   = 0;
   int   total    = 0;
   int   done_cnt = 0;

   mult_div_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .valid(valid), .funct(funct),
      .rs_val(rs_val), .rt_val(rt_val), .cancel(cancel),
      .hi(hi), .lo(lo), .busy(busy), .done(done),
      .div_zero(div_zero), .stall(stall)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // monitor: pop the scoreboard on every done pulse
   always @(negedge clk) begin
      if (!rst && done) begin
         exp_t e;
         done_cnt++;
         if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            e = sb.pop_front();
            check({e.name, "_hi"}, hi, e.hi);
            check({e.name, "_lo"}, lo, e.lo);
            check({e.name, "_dz"}, div_zero, e.dz);
         end
      end
      if (!rst && div_zero && !done) check("div_zero_without_done", 1, 0);
   end

   task automatic expect_op(input string nm, input logic [31:0] h, input logic [31:0] l, input logic dz);
      exp_t e;
      e.name = nm; e.hi = h; e.lo = l; e.dz = dz;
      sb.push_back(e);
   endtask

   task automatic go(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      valid = 1'b1; funct = f; rs_val = a; rt_val = b;
      @(posedge clk);
      #1 valid = 1'b0;
   endtask

   // lat: edges from start to done; bcnt/scnt: cycles with busy/stall high
   task automatic wait_done(output int lat, output int bcnt, output int scnt);
      lat = -1; bcnt = 0; scnt = 0;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (busy) bcnt++;
         if (stall) scnt++;
         if (done) begin
            lat = i - 1;
            break;
         end
      end
      if (lat < 0) check("done_timeout", 0, 1);
   endtask

   initial begin
      int lat, bc, sc, dc;
      rst = 1'b1; valid = 1'b0; funct = '0; rs_val = '0; rt_val = '0; cancel = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_hi", hi, 0);
      check("reset_lo", lo, 0);
      check("reset_flags", {busy, done, div_zero, stall}, 0);

      // signed multiply; an unrelated funct while busy must not stall
      expect_op("mult_m3x7", 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
      go(F_MULT, 32'hFFFFFFFD, 32'd7);
      valid = 1'b1; funct = F_ADD;
      wait_done(lat, bc, sc);
      valid = 1'b0;
      check("mult_latency", lat, 33);
      check("mult_busy_cycles", bc, 33);
      check("add_no_stall", sc, 0);
      @(negedge clk);
      check("done_one_cycle", done, 0);

      expect_op("multu_max", 32'hFFFFFFFE, 32'h00000001, 1'b0);
      go(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_done(lat, bc, sc);
      @(negedge clk);
      expect_op("div_m7_2", 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      go(F_DIV, 32'hFFFFFFF9, 32'd2);
      wait_done(lat, bc, sc);
      @(negedge clk);

      expect_op("divu_zero", 32'h00000064, 32'hFFFFFFFF, 1'b1);
      go(F_DIVU, 32'd100, 32'd0);
      wait_done(lat, bc, sc);
      @(negedge clk);
      check("div_zero_one_cycle", div_zero, 0);
      expect_op("div_overflow", 32'h00000000, 32'h80000000, 1'b0);
      go(F_DIV, 32'h80000000, 32'hFFFFFFFF);
      wait_done(lat, bc, sc);
      @(negedge clk);

      // mthi then mult the next cycle, mfhi held while busy
      go(F_MTHI, 32'h12345678, 32'd0);
      @(negedge clk);
      check("mthi_hi", hi, 32'h12345678);
      check("mthi_not_busy", busy, 0);
      expect_op("mult_2x3", 32'h00000000, 32'h00000006, 1'b0);
      go(F_MULT, 32'd2, 32'd3);
      valid = 1'b1; funct = F_MFHI;
      wait_done(lat, bc, sc);
      check("mfhi_stall_cycles", sc, 33);
      check("mfhi_no_stall_in_done", stall, 0);
      valid = 1'b0;
      @(negedge clk);

      // cancel at CALC counter 10
      go(F_DIV, 32'd50, 32'd7);
      repeat (11) @(negedge clk);
      check("busy_before_cancel", busy, 1);
      cancel = 1'b1;
      @(posedge clk);
      #1 cancel = 1'b0;
      dc = done_cnt;
      @(negedge clk);
      check("cancel_idle", busy, 0);
      repeat (40) @(negedge clk);
      check("cancel_no_done", done_cnt, dc);
      check("cancel_hi_kept", hi, 32'h0);
      check("cancel_lo_kept", lo, 32'h6);

      // reset mid-multiply
      go(F_MULT, 32'd4, 32'd5);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      dc = done_cnt;
      @(negedge clk);
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      check("rst_busy", busy, 0);
      repeat (40) @(negedge clk);
      check("rst_no_done", done_cnt, dc);

      // back-to-back: second op issued in the DONE cycle of the first
      expect_op("divu_50_7", 32'd1, 32'd7, 1'b0);
      expect_op("mult_4x5", 32'd0, 32'd20, 1'b0);
      go(F_DIVU, 32'd50, 32'd7);
      wait_done(lat, bc, sc);
      go(F_MULT, 32'd4, 32'd5);
      @(negedge clk);
      check("b2b_no_gap", busy, 1);
      wait_done(lat, bc, sc);
      check("b2b_latency", lat, 32);
      @(negedge clk);
      check("scoreboard_empty", sb.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/mult_div_unit.md
Name:
mult_div_unit

Overview:
Parametrised iterative multiply/divide unit with HI/LO registers. It executes the MIPS R-type funct codes mult, multu, div, divu, mfhi, mthi, mflo and mtlo, which the combinational ALU decoder does not handle. It sits beside the ALU in EX and produces a pipeline stall while a multi-cycle operation is in flight.

Parameters:
WIDTH, 32, operand/HI/LO width in bits; must be at least 4; iteration count equals WIDTH.

Ports:
clk  in  1  system clock; all state updates on its rising edge.
rst  in  1  synchronous, active-high reset.
valid  in  1  an R-type instruction is present in EX and not squashed; funct/rs_val/rt_val are meaningful.
funct  in  6  function field of that instruction.
rs_val  in  WIDTH  rs operand: multiplicand/dividend; source for mthi/mtlo.
rt_val  in  WIDTH  rt operand: multiplier/divisor.
cancel  in  1  abort any in-flight operation (exception/flush).
hi  out  WIDTH  HI register, registered.
lo  out  WIDTH  LO register, registered.
busy  out  1  high in CALC and FIX.
done  out  1  one-cycle pulse in DONE; hi/lo already hold the new result.
div_zero  out  1  high with done when the completed op was div/divu with rt_val==0; otherwise 0.
stall  out  1  combinational: busy & valid & (funct is any of the 8 codes below).

Behaviour:
- Decode, valid=1 only: 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu, 0x10 mfhi, 0x11 mthi, 0x12 mflo, 0x13 mtlo. All other funct values are ignored (no state change, no stall).
- Reset: FSM=IDLE; hi=0, lo=0, busy=0, done=0, div_zero=0; operand, counter and sign registers cleared.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE or DONE + valid + mult/multu/div/divu:
  - capture |rs|, |rt| (absolute values for signed ops, raw values for unsigned), the result signs, op type and divisor-zero flag;
  - counter=0; go to CALC.
- CALC: one iteration per cycle for exactly WIDTH cycles, counter 0..WIDTH-1; at counter==WIDTH-1 go to FIX.
  - Multiply: shift-add into a 2*WIDTH product.
  - Divide: restoring, one quotient bit per cycle, WIDTH-bit remainder with a carry bit.
- FIX, one cycle: apply sign correction, write hi/lo, go to DONE.
  - Signed product: negate the 2*WIDTH product when the operand signs differ. hi = upper half, lo = lower half.
  - Signed quotient: negate when the signs differ. Signed remainder takes the sign of the dividend. lo = quotient, hi = remainder.
- DONE, one cycle: done=1; go to IDLE unless a new op starts (back-to-back allowed).
- Latency: start sampled at edge 0 -> hi/lo update and done rises at edge WIDTH+1. busy is high for WIDTH+1 cycles.
- Divide by zero: hi=dividend (rs_val as given, unmodified), lo=all ones, div_zero=1 with done. Applies to both div and divu.
- Signed overflow, div of MIN by -1: lo=MIN, hi=0; div_zero=0.
- mthi/mtlo in IDLE or DONE: write rs_val to hi/lo at the next edge; single cycle, no busy.
- mfhi/mflo: no state change; the datapath reads hi/lo directly. They stall only while busy.
- Any listed op while busy: no effect, stall=1; the pipeline holds and re-presents it.
- cancel:
  - Highest priority. In CALC/FIX -> IDLE next edge; hi/lo keep their previous values; no done pulse.
  - In IDLE/DONE, cancel with a start or mthi/mtlo in the same cycle drops that op.
- rst mid-operation: identical to reset; no done pulse.
- All arithmetic is modulo 2^WIDTH or 2^(2*WIDTH); no exceptions are raised.

Test Plan:
- WIDTH=32, reset, then mult rs=0xFFFFFFFD (-3), rt=7 -> done at start+33 edges; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for 33 cycles.
- multu rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then div rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu rs=100, rt=0 -> hi=0x00000064, lo=0xFFFFFFFF, div_zero=1 for exactly one cycle. Then div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- mthi 0x12345678, then mult 2*3 issued the cycle after; mfhi presented while busy -> stall=1 every cycle until DONE; hi=0, lo=6.
- cancel asserted at CALC counter 10 of div 50/7 -> IDLE next edge, no done, hi/lo unchanged. rst asserted mid-mult -> hi=lo=0, busy=0.
- Back-to-back: divu 50/7 followed by mult 4*5 issued in its DONE cycle -> first hi=1, lo=7; second starts without an idle gap, lo=20.
